cmt_trace_buf: RTL
==================

CMT_TRACE_BUF -- requirements
Module: cmt_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries; power of two, >= 2.
REQ-002 SHALL have parameter PC_WD, default 64, commit PC width.
REQ-003 SHALL have parameter INST_WD, default 32, instruction width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmt_valid  input  1  one instruction retires this cycle.
REQ-007 SHALL have port cmt_pc  input  PC_WD  PC of retiring instruction.
REQ-008 SHALL have port cmt_inst  input  INST_WD  encoding of retiring instruction.
REQ-009 SHALL have port cmt_exp  input  1  retiring instruction raised an exception.
REQ-010 SHALL have port cmt_mret  input  1  retiring instruction is mret.
REQ-011 SHALL have port halt  input  1  simulation stop request (ebreak commit).
REQ-012 SHALL have port out_valid  output  1  drain entry available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts entry.
REQ-014 SHALL have ports out_pc/out_inst/out_exp/out_mret  output  PC_WD/INST_WD/1/1  oldest stored entry.
REQ-015 SHALL have port out_last  output  1  current out entry is the final one.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  entries held.
REQ-017 SHALL have port drop_cnt  output  32  commits lost to a full buffer.
REQ-018 SHALL have port done  output  1  drain complete.

Function
REQ-019 SHALL implement states CAPTURE, DRAIN, DONE; reset state CAPTURE.
REQ-020 In CAPTURE, cmt_valid=1 SHALL write {pc,inst,exp,mret} at write pointer, advance it modulo DEPTH, count+1, same cycle visible next cycle.
REQ-021 In CAPTURE, halt=1 SHALL move to DRAIN next cycle; a commit in the halt cycle SHALL be captured.
REQ-022 If halt=1 and buffer empty after that cycle's capture, SHALL move to DONE instead of DRAIN.
REQ-023 In DRAIN, out_valid SHALL equal (count!=0); out_* SHALL show entry at read pointer combinationally from storage.
REQ-024 out_valid & out_ready SHALL pop: read pointer advances modulo DEPTH, count-1.
REQ-025 out_last SHALL be 1 iff state DRAIN and count==1.
REQ-026 Pop of the last entry SHALL move to DONE next cycle; done=1 only in DONE, held until reset.
REQ-027 cmt_valid and halt SHALL be ignored in DRAIN and DONE; out_valid=0 outside DRAIN.
REQ-028 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-029 drop_cnt SHALL saturate at 32'hFFFFFFFF.
REQ-030 out_valid SHALL NOT drop while out_ready=0 and data SHALL stay stable.

Reset
REQ-031 reset=1 SHALL set state CAPTURE, pointers 0, count 0, drop_cnt 0, done 0, out_valid 0, out_last 0; entry storage need not be cleared.
REQ-032 reset SHALL take priority over any simultaneous commit, halt or pop, including mid-drain; entries are discarded.

Configuration
REQ-033 With CMT_TRACE_OVERWRITE_EN defined, a commit while count==DEPTH in CAPTURE SHALL overwrite the oldest entry, advance both pointers, keep count=DEPTH, increment drop_cnt (ring-trace mode: newest DEPTH kept).
REQ-034 Without CMT_TRACE_OVERWRITE_EN, a commit while count==DEPTH SHALL be discarded, storage and pointers unchanged, drop_cnt incremented (oldest DEPTH kept).

Verification
REQ-035 DEPTH=16: 3 commits pc 0x80000000/04/08, halt with 3rd, out_ready=1 -> out pcs 0x80000000,04,08 on consecutive cycles, out_last on 3rd, done=1 cycle after.
REQ-036 Overwrite build, 20 commits pc 0x80000000+4*i then halt -> drain yields i=4..19, drop_cnt=4, count=16 before drain.
REQ-037 Non-overwrite build, same stimulus -> drain yields i=0..15, drop_cnt=4.
REQ-038 Halt with empty buffer, no commit -> DONE next cycle, out_valid never 1, done=1.
REQ-039 Drain with out_ready toggling 1,0,0,1 and cmt_exp=1 on entry 2 -> each entry held stable while stalled, out_exp=1 only for entry 2, commits during DRAIN not stored.
REQ-040 reset pulsed mid-drain with count=5 -> next cycle count=0, out_valid=0, done=0, state CAPTURE, new commit stored at index 0.

Source files
------------

// File: rtl/cmt_trace_buf.sv
// cmt_trace_buf: commit trace buffer.
// Captures retiring instructions into a DEPTH-entry ring while in CAPTURE,
// then on a halt request drains them oldest-first over a valid/ready port
// and parks in DONE until reset.
// Build option: define CMT_TRACE_OVERWRITE_EN to keep the newest DEPTH
// commits (ring-trace mode) instead of the oldest DEPTH.
//
// Handshake: out_valid is asserted only in DRAIN while entries remain; an
// entry transfers on a clock edge where out_valid && out_ready. While
// out_ready is low, out_valid and all out_* fields hold steady.
module cmt_trace_buf #(
  parameter int DEPTH   = 16,
  parameter int PC_WD   = 64,
  parameter int INST_WD = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmt_valid,
  input  logic [PC_WD-1:0]           cmt_pc,
  input  logic [INST_WD-1:0]         cmt_inst,
  input  logic                       cmt_exp,
  input  logic                       cmt_mret,
  input  logic                       halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WD-1:0]           out_pc,
  output logic [INST_WD-1:0]         out_inst,
  output logic                       out_exp,
  output logic                       out_mret,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                drop_cnt,
  output logic                       done,
  output logic [1:0]                 state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

`ifdef CMT_TRACE_OVERWRITE_EN
  localparam logic OVERWRITE = 1'b1;
`else
  localparam logic OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PC_WD-1:0]   pc_mem   [DEPTH];
  logic [INST_WD-1:0] inst_mem [DEPTH];
  logic               exp_mem  [DEPTH];
  logic               mret_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty;
  logic             cap_commit;
  logic             store;
  logic             pop;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign cap_commit = (state == CAPTURE) && cmt_valid;
  // A full buffer only accepts the commit when overwriting the oldest entry.
  assign store      = cap_commit && (!full || OVERWRITE);
  assign pop        = out_valid && out_ready;

  // Drain-side outputs read storage directly at the read pointer.
  always_comb begin
    out_valid = (state == DRAIN) && !empty;
    out_last  = (state == DRAIN) && (count == ONE_CNT);
    done      = (state == DONE);
    state_dbg = state;
    out_pc    = pc_mem[rd_ptr];
    out_inst  = inst_mem[rd_ptr];
    out_exp   = exp_mem[rd_ptr];
    out_mret  = mret_mem[rd_ptr];
  end

  // Next-state logic: halt ends capture, last pop ends drain, DONE is sticky.
  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: if (halt) state_nxt = (empty && !cmt_valid) ? DONE : DRAIN;
      DRAIN:   if (pop && (count == ONE_CNT)) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = CAPTURE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= CAPTURE;
    else       state <= state_nxt;
  end

  // Pointers, occupancy and drop counter. Stores only happen in CAPTURE and
  // pops only in DRAIN, so count never moves both ways in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      // Overwriting a full ring also retires the oldest entry.
      if (pop || (store && full)) rd_ptr <= rd_ptr + PTR_W'(1);
      if (store && !full) count <= count + ONE_CNT;
      else if (pop)       count <= count - ONE_CNT;
      if (cap_commit && full && (drop_cnt != 32'hFFFF_FFFF))
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset && store) begin
      pc_mem[wr_ptr]   <= cmt_pc;
      inst_mem[wr_ptr] <= cmt_inst;
      exp_mem[wr_ptr]  <= cmt_exp;
      mret_mem[wr_ptr] <= cmt_mret;
    end
  end

endmodule
